// File: rtl/chimera_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chimera_dispatch_pkg
//  Description : Shared constants and types for the task dispatcher and its
//                round-robin arbiter. Defines the task word width, the PE
//                count, the PE index width and the default watchdog sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package chimera_dispatch_pkg;

    localparam int TASK_SIZE       = 144;
    localparam int NUM_PE          = 4;
    localparam int PE_ID_W         = $clog2(NUM_PE);
    localparam int DEFAULT_TIMEOUT = 4096;
    localparam int WD_W            = $clog2(DEFAULT_TIMEOUT + 1);

    typedef logic [TASK_SIZE-1:0] task_t;
    typedef logic [NUM_PE-1:0]    pe_mask_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first set bit
//                of req at or after ptr, wrapping modulo NUM_PE.
//  Ports       : req      - request mask
//                ptr      - search start index (always < NUM_PE)
//                grant    - one-hot grant
//                grant_id - index of the granted bit
//                any      - high when req is non-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import chimera_dispatch_pkg::*;
(
    input  pe_mask_t           req,
    input  logic [PE_ID_W-1:0] ptr,
    output pe_mask_t           grant,
    output logic [PE_ID_W-1:0] grant_id,
    output logic               any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [PE_ID_W:0]   sum;
    logic [PE_ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int off = 0; off < NUM_PE; off++) begin
            sum = {1'b0, ptr} + (PE_ID_W + 1)'(off);
            if (sum >= (PE_ID_W + 1)'(NUM_PE)) begin
                sum = sum - (PE_ID_W + 1)'(NUM_PE);
            end
            idx = sum[PE_ID_W-1:0];
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/task_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : task_dispatcher
//  Description : Dispatches tasks from the input buffer onto NUM_PE
//                processing elements, round-robin over free PEs. Tracks
//                per-PE busy state from done pulses and frees hung PEs with
//                a per-PE watchdog (TIMEOUT = 0 disables it).
//  Ports       : clk, rstn          - clock, async active-low reset
//                cfg_enable         - allow requesting new tasks
//                buf_valid/buf_data - task strobe and word from the buffer
//                buf_ready          - registered request to the buffer
//                pe_valid/pe_data   - one-hot dispatch strobe, shared bus
//                pe_done            - per-PE completion pulses
//                busy_mask          - per-PE busy state
//                dispatch_cnt       - dispatched tasks (wraps)
//                drop_cnt           - dropped tasks (saturates)
//                err_spurious       - sticky: done from an idle PE
//                timeout_flag       - sticky per-PE watchdog expiry
//  Revision    : 1.0 - initial release
// ============================================================================
module task_dispatcher
    import chimera_dispatch_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_enable,
    input  logic                 buf_valid,
    input  logic [TASK_SIZE-1:0] buf_data,
    output logic                 buf_ready,
    output logic [NUM_PE-1:0]    pe_valid,
    output logic [TASK_SIZE-1:0] pe_data,
    input  logic [NUM_PE-1:0]    pe_done,
    output logic [NUM_PE-1:0]    busy_mask,
    output logic [31:0]          dispatch_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 err_spurious,
    output logic [NUM_PE-1:0]    timeout_flag
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    pe_mask_t           busy_q, busy_d;
    pe_mask_t           pe_valid_q, pe_valid_d;
    pe_mask_t           timeout_q, timeout_d;
    task_t              pe_data_q, pe_data_d;
    logic [PE_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]        disp_q, disp_d;
    logic [15:0]        drop_q, drop_d;
    logic               buf_ready_q, buf_ready_d;
    logic               err_q, err_d;

    pe_mask_t           free;
    pe_mask_t           grant;
    pe_mask_t           timeout_hit;
    logic [PE_ID_W-1:0] grant_id;
    logic               any_free;
    logic               dispatch;

    // A PE signalling done this cycle may take the next task immediately.
    assign free     = ~busy_q | pe_done;
    assign dispatch = buf_valid & any_free;

    rr_arbiter u_arb (
        .req      (free),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_free)
    );

    generate
        for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
            if (TIMEOUT > 0) begin : g_wd
                logic [CNT_W-1:0] wd_q, wd_d;

                // Counts busy cycles; it stops at TIMEOUT because busy is
                // cleared on the same edge, so it never wraps.
                always_comb begin
                    wd_d = wd_q;
                    if (dispatch && grant[i]) begin
                        wd_d = '0;
                    end else if (busy_q[i]) begin
                        wd_d = wd_q + CNT_W'(1);
                    end
                end

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        wd_q <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
                end

                // A done pulse in the final cycle wins over the watchdog.
                assign timeout_hit[i] = busy_q[i] & ~pe_done[i] & (wd_q == C_WD_LAST);
            end else begin : g_no_wd
                assign timeout_hit[i] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        busy_d      = (busy_q & ~pe_done & ~timeout_hit) | (dispatch ? grant : '0);
        err_d       = err_q | (|(pe_done & ~busy_q));
        timeout_d   = timeout_q | timeout_hit;
        pe_valid_d  = dispatch ? grant : '0;
        pe_data_d   = dispatch ? buf_data : pe_data_q;
        rr_ptr_d    = rr_ptr_q;
        disp_d      = disp_q;
        drop_d      = drop_q;
        if (dispatch) begin
            rr_ptr_d = (grant_id == PE_ID_W'(NUM_PE - 1)) ? '0 : grant_id + PE_ID_W'(1);
            disp_d   = disp_q + 32'd1;
        end else if (buf_valid && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        // Based on post-update busy so ready drops right after the last PE
        // is claimed and the buffer cannot overcommit.
        buf_ready_d = cfg_enable & (busy_d != '1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q      <= '0;
            pe_valid_q  <= '0;
            timeout_q   <= '0;
            pe_data_q   <= '0;
            rr_ptr_q    <= '0;
            disp_q      <= '0;
            drop_q      <= '0;
            buf_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            pe_valid_q  <= pe_valid_d;
            timeout_q   <= timeout_d;
            pe_data_q   <= pe_data_d;
            rr_ptr_q    <= rr_ptr_d;
            disp_q      <= disp_d;
            drop_q      <= drop_d;
            buf_ready_q <= buf_ready_d;
            err_q       <= err_d;
        end
    end

    assign buf_ready    = buf_ready_q;
    assign pe_valid     = pe_valid_q;
    assign pe_data      = pe_data_q;
    assign busy_mask    = busy_q;
    assign dispatch_cnt = disp_q;
    assign drop_cnt     = drop_q;
    assign err_spurious = err_q;
    assign timeout_flag = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_task_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_task_dispatcher
//  Description : Self-checking bench for task_dispatcher. A reference model
//                predicts dispatches into a scoreboard queue consumed by a
//                monitor; per-cycle status outputs are compared against the
//                model. Directed scenarios followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_task_dispatcher;
    import chimera_dispatch_pkg::*;

    localparam int TIMEOUT = 16;

    logic                 clk        = 1'b0;
    logic                 rstn       = 1'b0;
    logic                 cfg_enable = 1'b1;
    logic                 buf_valid  = 1'b0;
    logic [TASK_SIZE-1:0] buf_data   = '0;
    logic [NUM_PE-1:0]    pe_done    = '0;
    logic                 buf_ready;
    logic [NUM_PE-1:0]    pe_valid;
    logic [TASK_SIZE-1:0] pe_data;
    logic [NUM_PE-1:0]    busy_mask;
    logic [31:0]          dispatch_cnt;
    logic [15:0]          drop_cnt;
    logic                 err_spurious;
    logic [NUM_PE-1:0]    timeout_flag;

    task_dispatcher #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_enable   (cfg_enable),
        .buf_valid    (buf_valid),
        .buf_data     (buf_data),
        .buf_ready    (buf_ready),
        .pe_valid     (pe_valid),
        .pe_data      (pe_data),
        .pe_done      (pe_done),
        .busy_mask    (busy_mask),
        .dispatch_cnt (dispatch_cnt),
        .drop_cnt     (drop_cnt),
        .err_spurious (err_spurious),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int                   k;
        logic [TASK_SIZE-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    bit          m_busy  [NUM_PE];
    int          m_start [NUM_PE];
    bit          m_tflag [NUM_PE];
    int          m_rr;
    logic [31:0] m_disp;
    int          m_drop;
    bit          m_err;
    bit          m_ready;
    int          now = 0;

    task automatic chk(input string name, input logic [TASK_SIZE-1:0] act,
                       input logic [TASK_SIZE-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [NUM_PE-1:0] busy_vec();
        logic [NUM_PE-1:0] v = '0;
        for (int i = 0; i < NUM_PE; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [NUM_PE-1:0] tflag_vec();
        logic [NUM_PE-1:0] v = '0;
        for (int i = 0; i < NUM_PE; i++) v[i] = m_tflag[i];
        return v;
    endfunction

    function automatic logic [TASK_SIZE-1:0] rand_task();
        logic [TASK_SIZE-1:0] v = '0;
        for (int i = 0; i < (TASK_SIZE + 31) / 32; i++) v = (v << 32) | TASK_SIZE'($urandom);
        return v;
    endfunction

    // Apply current inputs for one clock: model the cycle, then compare.
    task automatic step();
        bit                   nb[NUM_PE];
        int                   k;
        bit                   all_busy;
        bit                   push;
        exp_t                 e;
        nb   = m_busy;
        k    = -1;
        push = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_done[i]) begin
                if (m_busy[i]) nb[i] = 0;
                else m_err = 1;
            end else if (m_busy[i] && (now - m_start[i] == TIMEOUT)) begin
                nb[i]      = 0;
                m_tflag[i] = 1;
            end
        end
        if (buf_valid) begin
            for (int off = 0; off < NUM_PE; off++) begin
                int idx = (m_rr + off) % NUM_PE;
                if (k < 0 && (!m_busy[idx] || pe_done[idx])) k = idx;
            end
            if (k >= 0) begin
                nb[k]      = 1;
                m_start[k] = now;
                m_rr       = (k + 1) % NUM_PE;
                m_disp     = m_disp + 32'd1;
                e.k        = k;
                e.data     = buf_data;
                push       = 1;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        all_busy = 1;
        for (int i = 0; i < NUM_PE; i++) if (!nb[i]) all_busy = 0;
        m_ready = cfg_enable && !all_busy;
        m_busy  = nb;
        now++;
        @(posedge clk);
        if (push) sb_q.push_back(e);
        #1;
        chk("busy_mask",    busy_mask,    busy_vec());
        chk("buf_ready",    buf_ready,    m_ready);
        chk("dispatch_cnt", dispatch_cnt, m_disp);
        chk("drop_cnt",     drop_cnt,     m_drop[15:0]);
        chk("err_spurious", err_spurious, m_err);
        chk("timeout_flag", timeout_flag, tflag_vec());
        buf_valid = 1'b0;
        pe_done   = '0;
    endtask

    task automatic send(input logic [TASK_SIZE-1:0] d);
        buf_valid = 1'b1;
        buf_data  = d;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        buf_valid = 1'b0;
        pe_done   = '0;
        sb_q.delete();
        #1;
        chk("rst_pe_valid",  pe_valid,     '0);
        chk("rst_pe_data",   pe_data,      '0);
        chk("rst_busy",      busy_mask,    '0);
        chk("rst_buf_ready", buf_ready,    '0);
        chk("rst_disp",      dispatch_cnt, '0);
        chk("rst_drop",      drop_cnt,     '0);
        chk("rst_err",       err_spurious, '0);
        chk("rst_tflag",     timeout_flag, '0);
        for (int i = 0; i < NUM_PE; i++) begin
            m_busy[i]  = 0;
            m_tflag[i] = 0;
            m_start[i] = 0;
        end
        m_rr = 0; m_disp = '0; m_drop = 0; m_err = 0; m_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: every predicted dispatch must appear on the next negedge;
    // any other pe_valid activity is unexpected.
    exp_t              mon_e;
    logic [NUM_PE-1:0] mon_exp;
    always @(negedge clk) begin
        if (rstn) begin
            if (sb_q.size() > 0) begin
                mon_e        = sb_q.pop_front();
                mon_exp      = '0;
                mon_exp[mon_e.k] = 1'b1;
                chk("pe_valid", pe_valid, mon_exp);
                chk("pe_data",  pe_data,  mon_e.data);
            end else if (pe_valid != '0) begin
                chk("pe_valid_unexpected", pe_valid, '0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset();

        // Basic dispatch: PE0..PE3 in order, ready falls after the 4th.
        for (int d = 1; d <= 4; d++) begin
            send(TASK_SIZE'(d));
            if (d < 4) idle(3);
        end
        chk("basic_disp_cnt", dispatch_cnt, 32'd4);
        chk("basic_ready",    buf_ready,    1'b0);

        // Hole at PE2: next task fills it.
        pe_done = 4'b0100;
        step();
        chk("hole_busy",  busy_mask, 4'hB);
        chk("hole_ready", buf_ready, 1'b1);
        send(TASK_SIZE'(32'h55));

        // Same-cycle free and dispatch at the round-robin pointer.
        pe_done = '0;
        pe_done[m_rr] = 1'b1;
        send(TASK_SIZE'(32'hAB));
        chk("same_busy", busy_mask,    4'hF);
        chk("same_err",  err_spurious, 1'b0);

        // Overflow: all PEs busy, task dropped.
        send(TASK_SIZE'(32'hDEAD));
        chk("drop_one", drop_cnt, 16'd1);

        // Let everything time out, then a spurious done.
        idle(20);
        pe_done = 4'b0001;
        step();
        chk("spurious", err_spurious, 1'b1);

        // Reset while pe_valid is high.
        send(TASK_SIZE'(32'h77));
        chk("pre_rst_valid", (pe_valid != '0), 1'b1);
        do_reset();
        step();
        chk("post_rst_ready", buf_ready, 1'b1);

        // Watchdog on PE0; first dispatch after reset goes to PE0.
        send(TASK_SIZE'(32'h99));
        idle(TIMEOUT - 1);
        chk("wd_still_busy", busy_mask[0], 1'b1);
        idle(1);
        chk("wd_cleared", busy_mask[0], 1'b0);
        chk("wd_flag",    timeout_flag, 4'b0001);
        pe_done = 4'b0001;
        step();
        chk("wd_late_done", err_spurious, 1'b1);

        // Random traffic with occasional resets and enable toggles.
        for (int c = 0; c < 1500; c++) begin
            if (c % 500 == 250) begin
                send(rand_task());
                do_reset();
            end else begin
                if ($urandom_range(0, 49) == 0) cfg_enable = ~cfg_enable;
                buf_valid = ($urandom_range(0, 2) == 0);
                buf_data  = rand_task();
                for (int i = 0; i < NUM_PE; i++)
                    pe_done[i] = m_busy[i] ? ($urandom_range(0, 5) == 0)
                                           : ($urandom_range(0, 39) == 0);
                step();
            end
        end
        cfg_enable = 1'b1;
        idle(2);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
